// File: rtl/uart_rx_if.sv
// uart_rx_if: output side of the UART receiver.
//   data       - received word, stable while valid=1
//   valid      - data holds an unconsumed word
//   ready      - consumer accepts data when valid & ready
//   frame_err  - one-cycle pulse: stop bit sampled low
//   overrun    - one-cycle pulse: good frame dropped because valid was still set
//   parity_err - one-cycle pulse: even-parity mismatch (parity build only)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overrun;
    logic                  parity_err;

    modport master (output data, valid, frame_err, overrun, parity_err, input ready);
    modport slave  (input data, valid, frame_err, overrun, parity_err, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver (start, DATA_WIDTH data bits LSB
// first, optional even parity bit, one stop bit). Each bit is sampled once,
// near its middle, using a down-counter reloaded with CLK_FREQ/BAUD_RATE.
// Ports:
//   clk     - rising-edge system clock
//   rstn    - synchronous active-low reset
//   uart_in - asynchronous serial line, idle high
//   rx      - uart_rx_if.master: data/valid/ready handshake + error pulses
// Optional feature: define UART_RX_PARITY_EN to receive and check an
// even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_in,
    uart_rx_if.master   rx
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW               = $clog2(PULSE_WIDTH) + 1;
    localparam int IW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic                  sync1;
    logic                  rx_s;
    logic                  rx_prev;   // previous rx_s, for falling-edge detect
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_ok;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok        = ~^{shift, par_bit};
    assign rx.parity_err = perr_q;
`else
    assign par_ok        = 1'b1;
    assign rx.parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            sync1        <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            rx.data      <= '0;
            rx.valid     <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            sync1        <= uart_in;
            rx_s         <= sync1;
            rx_prev      <= rx_s;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
`endif
            // Consumption; a good frame in STOP below may reload in the same cycle.
            if (rx.valid && rx.ready)
                rx.valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= CW'(HALF_PULSE_WIDTH - 1);
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= CW'(PULSE_WIDTH - 1);
                            idx   <= '0;
                        end else begin
                            state <= IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift[idx] <= rx_s;
                        cnt        <= CW'(PULSE_WIDTH - 1);
                        if (idx == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        par_bit <= rx_s;
                        cnt     <= CW'(PULSE_WIDTH - 1);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (!rx_s) begin
                            rx.frame_err <= 1'b1;
                        end else if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
                            perr_q <= 1'b1;
`endif
                        end else if (!rx.valid || rx.ready) begin
                            rx.data  <= shift;
                            rx.valid <= 1'b1;
                        end else begin
                            rx.overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, giving the serial bit rate in bits per second.
REQ-003 The block SHALL have parameter CLK_FREQ, default 100_000_000, giving the clk frequency in Hz.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-005 The block SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port uart_in, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port data, output, DATA_WIDTH bits: received byte, stable while valid=1.
REQ-008 The block SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-009 The block SHALL have port ready, input, 1 bit: consumer accepts data when valid&ready.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good frame completes while valid=1.
REQ-012 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-013 The block SHALL derive PULSE_WIDTH=CLK_FREQ/BAUD_RATE and HALF_PULSE_WIDTH=PULSE_WIDTH/2 (integer division), with the bit-timing counter sized $clog2(PULSE_WIDTH)+1 bits.
REQ-014 The block SHALL pass uart_in through a 2-flop synchronizer (reset value 1) and use only the synchronized value (rx_s) internally.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and any illegal encoding SHALL return to IDLE.
REQ-016 In IDLE, an rx_s high-to-low transition SHALL enter START and load the counter with HALF_PULSE_WIDTH-1.
REQ-017 In START at counter 0, rx_s=0 SHALL enter DATA (counter=PULSE_WIDTH-1, bit index 0); rx_s=1 SHALL be a false start that returns to IDLE with no output pulse.
REQ-018 In DATA, each time the counter reaches 0 the block SHALL sample rx_s into shift bit [index], LSB first, and reload the counter with PULSE_WIDTH-1.
REQ-019 After sampling bit DATA_WIDTH-1, the FSM SHALL go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
REQ-020 In STOP at counter 0: rx_s=1 with parity OK SHALL be a good frame; rx_s=0 SHALL pulse frame_err and discard the byte; either way the FSM SHALL return to IDLE.
REQ-021 On a good frame with valid=0 (or valid&ready in the same cycle), data SHALL load and valid SHALL assert on the next clk edge.
REQ-022 On a good frame with valid=1 and ready=0, the block SHALL drop the new byte, pulse overrun, and leave data unchanged.
REQ-023 valid SHALL clear on the clk edge after valid&ready, unless REQ-021 reloads it in the same cycle.
REQ-024 Total latency SHALL be from the stop-bit sample edge to valid=1 = 1 clk.
REQ-025 While in IDLE waiting for a new start edge, the receiver SHALL be restartable immediately after STOP, with no extra idle time required.

Reset
REQ-026 When rstn=0 at a clk edge, the block SHALL go to state IDLE with counter=0, index=0, data=0, valid=0, frame_err=0, overrun=0, parity_err=0, and synchronizer flops=1.
REQ-027 A reset applied mid-frame SHALL abort the frame with no output pulse, and the next falling edge after reset release SHALL start a new frame.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit after the data, taking PULSE_WIDTH cycles.
REQ-029 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_err in the STOP sample cycle and discard the byte (no valid, no overrun).
REQ-030 With UART_RX_PARITY_EN undefined, the PARITY state SHALL be unreachable and parity_err SHALL be tied to 0.

Verification (CLK_FREQ=16, BAUD_RATE=1: PULSE_WIDTH=16)
REQ-031 The bench SHALL cover this scenario: frame 0xA5 with correct stop and ready=1 -> valid pulses 1 cycle with data=0xA5, and no error pulses.
REQ-032 The bench SHALL cover this scenario: low glitch of 5 cycles on idle line -> false start, no valid and no frame_err.
REQ-033 The bench SHALL cover this scenario: frame 0x3C with stop bit=0 -> frame_err pulses once, valid stays 0.
REQ-034 The bench SHALL cover this scenario: ready=0, frames 0x11 then 0x22 -> data=0x11 with valid held, and overrun pulses once at the end of the 0x22 frame.
REQ-035 The bench SHALL cover this scenario: rstn=0 during bit 4 of 0xFF, then frame 0x5A -> only 0x5A is delivered.
REQ-036 The bench SHALL cover this scenario (parity build): frame 0x07 with parity bit 0 (even parity needs 1) -> parity_err pulses once, valid stays 0.
